ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. Consumes the ID/EX register's operands, immediate, control bits and register indices. Resolves operand forwarding, performs ALU operations including a multi-cycle shift-add `mul`, and registers the result into the EX/MEM pipeline register. While a multiply is in progress it drives `stall_o` back to the ID/EX register's `stall_i` and feeds bubbles downstream.

---
 rtl/ex_pkg.sv | 45 ++++
 rtl/ex_stage_mul_seq.sv | 64 ++++++
 rtl/ex_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op classes, R-type funct codes,
// multiplier FSM states, EX/MEM control bit positions and the forwarding selector.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  localparam logic [1:0] FWD_RAW   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic exmem_wr, input logic [4:0] exmem_rd,
                                         input logic wb_wr, input logic [4:0] wb_rd,
                                         input logic [4:0] idx);
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == idx)) begin
      return FWD_EXMEM;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == idx)) begin
      return FWD_WB;
    end else begin
      return FWD_RAW;
    end
  endfunction

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Sequential shift-add multiplier: one entry cycle, WIDTH iterations, one DONE cycle.
// busy covers the entry cycle too, so it can drive the pipeline stall directly.
module mul_seq
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  // Multiplier FSM and shift-add datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mplier[0]) begin
            product <= product + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = ((state == S_IDLE) && start) || (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU with sequential mul, EX/MEM register.
// Bubbles are loaded into EX/MEM for every cycle the multiplier holds the stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [WIDTH-1:0] extend_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [3:0]       ctrl_i,
  input  logic [4:0]       MUX0_i,
  input  logic [4:0]       MUX1_i,
  input  logic [4:0]       inst0_i,
  input  logic [4:0]       inst1_i,
  input  logic             wb_RegWrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic [4:0]       rd_o,
  output logic [3:0]       ctrl_o,
  output logic             stall_o
);

  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu;
  logic [5:0]       funct;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] product;

  assign sel_a = fwd_sel(ctrl_o[CTRL_REGWRITE], rd_o, wb_RegWrite_i, wb_rd_i, inst0_i);
  assign sel_b = fwd_sel(ctrl_o[CTRL_REGWRITE], rd_o, wb_RegWrite_i, wb_rd_i, inst1_i);
  assign funct = extend_i[5:0];
  assign op_b  = ALUSrc_i ? extend_i : fwd_b;

  // Forwarding muxes for rs and rt
  always_comb begin
    fwd_a = data1_i;
    fwd_b = data2_i;
    case (sel_a)
      FWD_EXMEM: fwd_a = result_o;
      FWD_WB:    fwd_a = wb_data_i;
      default:   fwd_a = data1_i;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = result_o;
      FWD_WB:    fwd_b = wb_data_i;
      default:   fwd_b = data2_i;
    endcase
  end

  // ALU decode; unknown funct yields zero but control still passes through
  always_comb begin
    alu    = '0;
    is_mul = 1'b0;
    case (ALUOp_i)
      ALU_ADD: alu = fwd_a + op_b;
      ALU_SUB: alu = fwd_a - op_b;
      ALU_OR:  alu = fwd_a | op_b;
      ALU_FUNCT: begin
        case (funct)
          F_ADD:   alu = fwd_a + op_b;
          F_SUB:   alu = fwd_a - op_b;
          F_AND:   alu = fwd_a & op_b;
          F_OR:    alu = fwd_a | op_b;
          F_SLT:   alu = WIDTH'($signed(fwd_a) < $signed(op_b));
          F_MUL: begin
            is_mul = 1'b1;
            alu    = mul_done ? product : '0;
          end
          default: alu = '0;
        endcase
      end
      default: alu = '0;
    endcase
  end

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (is_mul),
    .a       (fwd_a),
    .b       (op_b),
    .busy    (stall_o),
    .done    (mul_done),
    .product (product)
  );

  // EX/MEM pipeline register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o <= '0;
      wdata_o  <= '0;
      rd_o     <= 5'd0;
      ctrl_o   <= 4'd0;
    end else if (stall_o) begin
      result_o <= '0;
      wdata_o  <= '0;
      rd_o     <= 5'd0;
      ctrl_o   <= 4'd0;
    end else begin
      result_o <= alu;
      wdata_o  <= fwd_b;
      rd_o     <= RegDst_i ? MUX1_i : MUX0_i;
      ctrl_o   <= ctrl_i;
    end
  end

endmodule
